regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Write-port arbiter and sequencer for the 16 x 32-bit register file. Collects register write-back requests from NREQ execution/load units over valid/ready handshakes and maps up to four of them per cycle onto the register file's four write ports. Requests to R15 are routed to the separate PC write port. Grant order is round-robin, and same-address collisions are resolved so that only one write per register issues per cycle. All register-file-facing outputs are registered.

## Interface
- NREQ, 6, number of requesters (2..8)
- N, 32, register data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i holds a write
- req_addr  in  4*NREQ  destination register of request i (slice [4i+3:4i])
- req_data  in  N*NREQ  write data of request i (slice [Ni+N-1:Ni])
- req_ready  out  NREQ  combinational grant; transfer when valid & ready
- write_address_1..4  out  4 each  register file write addresses
- write_data_1..4  out  N each  register file write data
- write_enable_1..4  out  1 each  register file write enables
- pc_update  out  N  new PC value
- pc_write  out  1  PC write strobe
- busy  out  1  registered; 1 if any request was left ungranted last cycle

## Operation
- Requesters scanned in order rr_ptr, rr_ptr+1, ... mod NREQ. A valid request is granted when all of the following hold:
  - addr != 15: fewer than 4 general grants so far this cycle.
  - addr == 15: PC slot not yet used this cycle.
  - No earlier grant this cycle has the same addr.
- Ungranted requests see req_ready = 0 and must hold addr/data stable.
- General grants fill ports in scan order: first grant -> port 1, second -> port 2, etc. Unused ports get enable 0; their address and data are held at the previous value.
- R15 grant drives pc_update and pc_write, never a general port. R15 is never written through write_address_x.
- rr_ptr: if at least one grant occurred, next rr_ptr = (index of last granted requester + 1) mod NREQ. Otherwise unchanged.
- A requester deasserting valid without ready is tolerated; it is simply not granted.
- busy = 1 when any request had valid & !ready this cycle.
- A requester with a continuously asserted valid is granted within NREQ cycles.

## Timing
- Grant decision is combinational from req_valid/req_addr and rr_ptr; the handshake completes at posedge k.
- Granted write appears on the outputs after posedge k, i.e. during cycle k+1. The register file commits it at the negedge inside cycle k+1. Latency is 1 cycle.
- Enables and pc_write are single-cycle pulses per grant. Back-to-back grants produce consecutive pulses.
- Reset (async assert, synchronous deassert at the user's side) forces:
  - all write_enable_x = 0, pc_write = 0, busy = 0
  - all addresses = 0, all data = 0, pc_update = 0
  - rr_ptr = 0
- Reset mid-operation drops any write accepted in the same cycle; nothing issues after deassert until new grants.
- Same-address requests in one cycle: the first in scan order wins. The loser retries next cycle and issues after the winner, preserving ordering.

## Structure
- Shared package regfile_pkg: REG_PC = 4'd15, NUM_WR_PORTS = 4, register address type (4 bits).
- One natural sub-module: rr_scan, a combinational rotate/scan that produces the grant vector and port index for each requester from valid, addresses and rr_ptr.
- Top level holds rr_ptr, output registers and busy.

## Test plan
- Reset: assert rst_n=0 with valid requests pending -> all enables, pc_write and busy 0; req_ready irrelevant; after release the first grant starts at requester 0.
- Six valid requests to R1..R6, rr_ptr=0 -> requesters 0..3 granted, ports 1..4 = R1..R4 next cycle, busy=1. Following cycle requesters 4,5 granted on ports 1,2; rr_ptr ends at 0.
- Requesters 1 and 3 both target R7 with data A and B -> cycle k issues R7<=A only. Cycle k+1 issues R7<=B; final R7 = B.
- Requester 2 writes R15=0x100 and requester 4 writes R15=0x200 -> pc_write with 0x100, then pc_write with 0x200. No general port enabled for R15.
- Requester 0 held valid continuously while 1..5 flood requests -> requester 0 granted at least once every 2 cycles and never starved beyond NREQ cycles.
- Single request R3=0xDEADBEEF in a cycle -> write_enable_1 = 1, write_address_1 = 3, write_data_1 = 0xDEADBEEF for exactly one cycle; ports 2..4 disabled.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: address type,
// the PC register number and the number of general write ports.
package regfile_pkg;

    typedef logic [3:0] reg_addr_t;

    localparam reg_addr_t REG_PC       = 4'd15;
    localparam int        NUM_WR_PORTS = 4;

    // Increment an index modulo n (n is small, so a compare beats a divider).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_scan.sv
// Combinational round-robin scan: walks the requesters starting at rr_ptr,
// grants up to four general writes plus one PC write per cycle, blocks any
// request whose register was already granted earlier in the scan, and
// reports the write port each general grant lands on.
module rr_scan
    import regfile_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int PW   = 3
) (
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [PW-1:0]     rr_ptr,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   pc_sel,
    output logic [2*NREQ-1:0] port_idx,
    output logic [PW-1:0]     next_ptr
);

    logic [15:0] taken;
    logic        pc_used;
    int          gcnt;
    int          idx;
    reg_addr_t   cur_addr;

    // Scan in rotated order; the first requester to claim a register wins it.
    always_comb begin
        grant    = '0;
        pc_sel   = '0;
        port_idx = '0;
        next_ptr = rr_ptr;
        taken    = '0;
        pc_used  = 1'b0;
        gcnt     = 0;
        idx      = 0;
        cur_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cur_addr = req_addr[4*idx +: 4];
            if (req_valid[idx] && !taken[cur_addr]) begin
                if (cur_addr == REG_PC) begin
                    if (!pc_used) begin
                        grant[idx]      = 1'b1;
                        pc_sel[idx]     = 1'b1;
                        pc_used         = 1'b1;
                        taken[cur_addr] = 1'b1;
                        next_ptr        = PW'(wrap_inc(idx, NREQ));
                    end
                end else if (gcnt < NUM_WR_PORTS) begin
                    grant[idx]          = 1'b1;
                    port_idx[2*idx +: 2] = gcnt[1:0];
                    gcnt                = gcnt + 1;
                    taken[cur_addr]     = 1'b1;
                    next_ptr            = PW'(wrap_inc(idx, NREQ));
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Grants requesters combinationally via
// rr_scan, then registers the granted writes onto four general ports and
// the PC port. Idle ports keep their last address/data; only enables pulse.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int N    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [N*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [3:0]        write_address_1,
    output logic [3:0]        write_address_2,
    output logic [3:0]        write_address_3,
    output logic [3:0]        write_address_4,
    output logic [N-1:0]      write_data_1,
    output logic [N-1:0]      write_data_2,
    output logic [N-1:0]      write_data_3,
    output logic [N-1:0]      write_data_4,
    output logic              write_enable_1,
    output logic              write_enable_2,
    output logic              write_enable_3,
    output logic              write_enable_4,
    output logic [N-1:0]      pc_update,
    output logic              pc_write,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           next_ptr;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         pc_sel;
    logic [2*NREQ-1:0]       port_idx;

    logic [NUM_WR_PORTS-1:0] port_en_p0;
    reg_addr_t               port_addr_p0 [NUM_WR_PORTS];
    logic [N-1:0]            port_data_p0 [NUM_WR_PORTS];
    logic                    pc_en_p0;
    logic [N-1:0]            pc_data_p0;

    logic [NUM_WR_PORTS-1:0] we_p1;
    reg_addr_t               wa_p1 [NUM_WR_PORTS];
    logic [N-1:0]            wd_p1 [NUM_WR_PORTS];
    logic                    pcw_p1;
    logic [N-1:0]            pcv_p1;
    logic                    busy_p1;

    rr_scan #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_scan (
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .pc_sel    (pc_sel),
        .port_idx  (port_idx),
        .next_ptr  (next_ptr)
    );

    assign req_ready = grant;

    // Steer each granted request onto its assigned port or the PC slot.
    always_comb begin
        port_en_p0 = '0;
        pc_en_p0   = 1'b0;
        pc_data_p0 = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            port_addr_p0[p] = '0;
            port_data_p0[p] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                if (pc_sel[i]) begin
                    pc_en_p0   = 1'b1;
                    pc_data_p0 = req_data[N*i +: N];
                end else begin
                    port_en_p0[port_idx[2*i +: 2]]   = 1'b1;
                    port_addr_p0[port_idx[2*i +: 2]] = req_addr[4*i +: 4];
                    port_data_p0[port_idx[2*i +: 2]] = req_data[N*i +: N];
                end
            end
        end
    end

    // p0 -> p1: register granted writes; idle ports hold address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            we_p1   <= '0;
            pcw_p1  <= 1'b0;
            pcv_p1  <= '0;
            busy_p1 <= 1'b0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                wa_p1[p] <= '0;
                wd_p1[p] <= '0;
            end
        end else begin
            rr_ptr  <= next_ptr;
            we_p1   <= port_en_p0;
            pcw_p1  <= pc_en_p0;
            busy_p1 <= |(req_valid & ~grant);
            if (pc_en_p0) pcv_p1 <= pc_data_p0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (port_en_p0[p]) begin
                    wa_p1[p] <= port_addr_p0[p];
                    wd_p1[p] <= port_data_p0[p];
                end
            end
        end
    end

    assign write_enable_1  = we_p1[0];
    assign write_enable_2  = we_p1[1];
    assign write_enable_3  = we_p1[2];
    assign write_enable_4  = we_p1[3];
    assign write_address_1 = wa_p1[0];
    assign write_address_2 = wa_p1[1];
    assign write_address_3 = wa_p1[2];
    assign write_address_4 = wa_p1[3];
    assign write_data_1    = wd_p1[0];
    assign write_data_2    = wd_p1[1];
    assign write_data_3    = wd_p1[2];
    assign write_data_4    = wd_p1[3];
    assign pc_update       = pcv_p1;
    assign pc_write        = pcw_p1;
    assign busy            = busy_p1;

endmodule
